avg_filter_sched: RTL
=====================

// Module: avg_filter_sched
// PURPOSE
//  Time-shares one moving-average datapath (running sum, oldest-sample subtract, >>AVE_DATA_BIT)
//  between CH_NUM sample streams (phase currents, bus voltage, speed). A round-robin arbiter
//  grants one request at a time. Per-channel history, sum, write pointer and fill count are held
//  internally. Sits between the ADC/encoder capture logic and the FOC current/speed loops.
// PARAMETERS
//  CH_NUM        4   number of requesters/channels (2..8)
//  DATA_W        32  sample and sum width
//  AVE_DATA_NUM  8   window length; must equal 2**AVE_DATA_BIT
//  AVE_DATA_BIT  3   log2 of window length; output shift
// PORTS
//  i_clk    in   1              clock
//  i_rst    in   1              reset, asynchronous, active-high
//  i_req    in   CH_NUM         per-channel sample request (level, held until o_ack)
//  i_din    in   CH_NUM*DATA_W  per-channel sample; channel k at [k*DATA_W +: DATA_W]
//  i_clr    in   CH_NUM         per-channel synchronous clear (1-cycle pulse)
//  o_ack    out  CH_NUM         one-hot 1-cycle pulse: sample of that channel accepted
//  o_dout   out  CH_NUM*DATA_W  per-channel average, same packing as i_din
//  o_valid  out  CH_NUM         1 once the channel window holds AVE_DATA_NUM samples
// BEHAVIOUR
//  Reset: o_ack=0, o_dout=0, o_valid=0; all sums, fill counts, write pointers =0; FSM=IDLE;
//   RR pointer=CH_NUM-1 (channel 0 wins first). History contents need not be cleared.
//  FSM IDLE -> READ -> UPDATE -> IDLE, one state per cycle:
//   IDLE:   if any i_req, pick first set bit searching from last_grant+1 (mod CH_NUM);
//           latch channel index and its i_din; last_grant<=index; go READ. Else stay.
//   READ:   fetch oldest = hist[ch][wptr[ch]].
//   UPDATE: old = (fill[ch]==AVE_DATA_NUM) ? oldest : 0;
//           sum[ch] <= sum[ch] + din - old; hist[ch][wptr[ch]] <= din;
//           wptr[ch] <= wptr[ch]+1 (wraps AVE_DATA_NUM-1 -> 0);
//           fill[ch] <= min(fill[ch]+1, AVE_DATA_NUM); o_ack[ch]=1 this cycle; go IDLE.
//  o_dout[ch] = sum[ch] >> AVE_DATA_BIT, registered; changes the cycle after UPDATE.
//  o_valid[ch] = (fill[ch]==AVE_DATA_NUM), registered alongside o_dout.
//  Arithmetic: unsigned, modulo 2**DATA_W; no saturation (a wrapped sum recovers once the
//   overflowing samples leave the window).
//  Latency: grant cycle to o_ack = 2 cycles; o_ack to new o_dout = 1 cycle.
//   Max throughput = one sample per 3 cycles total.
//  Handshake: requester holds i_req and i_din stable until o_ack, then drops i_req.
//   i_req still high in the IDLE after o_ack is a new request. i_din is sampled only in the
//   grant cycle. Dropping i_req before o_ack is illegal; the latched sample is still processed.
//  Clear: i_clr[k] sets sum[k]=0, fill[k]=0, wptr[k]=0, o_dout[k]=0, o_valid[k]=0 next cycle.
//   If the clear coincides with UPDATE of channel k, clear wins: the sample is dropped but
//   o_ack[k] still pulses. A clear on k during READ of channel k also drops that sample.
//   Clear of another channel does not disturb the in-flight operation.
//  Window < AVE_DATA_NUM samples: o_dout = partial sum >> AVE_DATA_BIT (underestimate);
//   consumers gate on o_valid.
//  Reset mid-operation aborts the in-flight sample with no o_ack.
// TESTING
//  1 ch0 requests 8x din=80 -> 8 acks; o_dout[0]=80 and o_valid[0] rise the cycle after ack 8, not before.
//  2 continue ch0 with din=160 -> sum=720, o_dout[0]=90; 8 more 160s -> o_dout[0]=160.
//  3 all i_req held high, 8 grants -> ack order 0,1,2,3,0,1,2,3; acks spaced 3 cycles apart.
//  4 ch1 at 5 samples, pulse i_clr[1] in its UPDATE cycle -> o_ack[1] pulses;
//    sum=0, o_valid[1]=0; 8 new samples needed for valid.
//  5 ch2 window of 0xFFFF_FFF0, then 0x20 -> sum wraps mod 2**32; after 8 samples of 0x20, o_dout[2]=0x20.
//  6 assert i_rst in a READ cycle -> no o_ack; all o_dout/o_valid=0; first grant after release goes to ch0.

Source files
------------

// File: rtl/avg_filter_sched.sv
// Round-robin scheduled moving-average filter: one shared sum/subtract/shift datapath
// time-shared between CH_NUM sample streams, with per-channel history, sum and fill state.
module avg_filter_sched #(
    parameter int CH_NUM       = 4,
    parameter int DATA_W       = 32,
    parameter int AVE_DATA_NUM = 8,
    parameter int AVE_DATA_BIT = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [CH_NUM-1:0]        i_req,
    input  logic [CH_NUM*DATA_W-1:0] i_din,
    input  logic [CH_NUM-1:0]        i_clr,
    output logic [CH_NUM-1:0]        o_ack,
    output logic [CH_NUM*DATA_W-1:0] o_dout,
    output logic [CH_NUM-1:0]        o_valid
);
    localparam int CH_W   = $clog2(CH_NUM);
    localparam int FILL_W = AVE_DATA_BIT + 1;
    localparam logic [FILL_W-1:0] FULL    = FILL_W'(AVE_DATA_NUM);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(CH_NUM - 1);

    typedef enum logic [1:0] {IDLE, READ, UPDATE} state_t;
    state_t state, state_next;

    logic [CH_W-1:0]   last_grant, cur_ch, grant_idx;
    logic              grant_found;
    logic [DATA_W-1:0] cur_din, oldest;
    logic              drop;

    logic [DATA_W-1:0]       hist [CH_NUM][AVE_DATA_NUM];
    logic [DATA_W-1:0]       sum  [CH_NUM];
    logic [DATA_W-1:0]       dout [CH_NUM];
    logic [FILL_W-1:0]       fill [CH_NUM];
    logic [AVE_DATA_BIT-1:0] wptr [CH_NUM];

    logic              upd_en;
    logic [DATA_W-1:0] old_term, sum_new;
    logic [FILL_W-1:0] fill_new;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        logic [CH_W-1:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 1; i <= CH_NUM; i++) begin
            cand = CH_W'((int'(last_grant) + i) % CH_NUM);
            if (!grant_found && i_req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = READ;
            READ:    state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A clear landing on the active channel while its oldest sample is fetched
    // marks the operation as dropped; the ack still goes out in UPDATE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant <= LAST_CH;
            cur_ch     <= '0;
            cur_din    <= '0;
            oldest     <= '0;
            drop       <= 1'b0;
            o_ack      <= '0;
        end else begin
            o_ack <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        last_grant <= grant_idx;
                        cur_ch     <= grant_idx;
                        cur_din    <= i_din[grant_idx*DATA_W +: DATA_W];
                        drop       <= 1'b0;
                    end
                end
                READ: begin
                    oldest        <= hist[cur_ch][wptr[cur_ch]];
                    drop          <= i_clr[cur_ch];
                    o_ack[cur_ch] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        old_term = (fill[cur_ch] == FULL) ? oldest : '0;
        sum_new  = sum[cur_ch] + cur_din - old_term;
        fill_new = (fill[cur_ch] == FULL) ? FULL : fill[cur_ch] + 1'b1;
        upd_en   = (state == UPDATE) && !drop && !i_clr[cur_ch];
    end

    // Clear always beats an update of the same channel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < CH_NUM; k++) begin
                sum[k]     <= '0;
                fill[k]    <= '0;
                wptr[k]    <= '0;
                dout[k]    <= '0;
                o_valid[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (i_clr[k]) begin
                    sum[k]     <= '0;
                    fill[k]    <= '0;
                    wptr[k]    <= '0;
                    dout[k]    <= '0;
                    o_valid[k] <= 1'b0;
                end else if (upd_en && cur_ch == CH_W'(k)) begin
                    sum[k]     <= sum_new;
                    fill[k]    <= fill_new;
                    wptr[k]    <= wptr[k] + 1'b1;
                    dout[k]    <= sum_new >> AVE_DATA_BIT;
                    o_valid[k] <= (fill_new == FULL);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (upd_en) hist[cur_ch][wptr[cur_ch]] <= cur_din;
    end

    for (genvar k = 0; k < CH_NUM; k++) begin : g_pack
        assign o_dout[k*DATA_W +: DATA_W] = dout[k];
    end

endmodule
